// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types and constants for the unified-memory port arbiter.
//   arb_state_t : access sequencer states IDLE -> ISSUE -> WAIT -> RESP
//   REQ_IF      : requester index of instruction fetch
//   REQ_LS      : requester index of load/store
//   ARB_CNT_W   : width of the memory-latency down-counter
//   grant_onehot: expands a requester index into a 2-bit one-hot vector
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int REQ_IF    = 0;
    localparam int REQ_LS    = 1;
    localparam int ARB_CNT_W = 4;

    function automatic logic [1:0] grant_onehot(logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Request/response bus of the two memory requesters plus the memory-side
// access bus. The arbiter uses the slave modport; the surrounding core and
// memory array (or a testbench standing in for them) use the master modport.
//   req_valid/req_ready/req_we : per-requester handshake, [0]=fetch [1]=LSU
//   req_addr/req_wdata         : per-requester address/data, packed {r1,r0}
//   rsp_valid/rsp_rdata        : one-cycle response pulse and shared read data
//   mem_en/mem_we/mem_addr/mem_wdata : memory strobe and write/address bus
//   mem_rdata                  : memory read data, MEM_LAT cycles after mem_en
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_we;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner select for the two memory requesters.
//   req_valid  in  2  per-requester valid, [0]=fetch [1]=LSU
//   last_grant in  1  index of the last accepted requester
//   grant_idx  out 1  index of the winner (meaningful when any_valid)
//   any_valid  out 1  at least one requester is valid
// Build option MEM_PORT_ARB_RR_EN: on contention grant the requester that was
// not granted last. Without it, LSU always wins contention and last_grant is
// ignored.
// -----------------------------------------------------------------------------
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       grant_idx,
    output logic       any_valid
);

    assign any_valid = |req_valid;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_idx = 1'b0;
        if (req_valid == 2'b11) begin
`ifdef MEM_PORT_ARB_RR_EN
            grant_idx = ~last_grant;
`else
            grant_idx = 1'(REQ_LS);
`endif
        end else begin
            // A lone requester always wins, in either build.
            grant_idx = req_valid[REQ_LS];
        end
    end

`ifndef MEM_PORT_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-ported unified word memory between instruction fetch
// (req 0) and load/store (req 1). One access is in flight at a time and is
// sequenced accept -> issue -> wait MEM_LAT -> respond.
//   clk   in   single clock, all state on posedge
//   rst   in   asynchronous, active-high reset; drops any in-flight access
//   bus   slave modport of mem_port_arbiter_if (request, response, memory)
//   busy  out  high whenever the sequencer is not IDLE
// Parameters: ADDR_W word-address width, DATA_W data width,
//             MEM_LAT memory read latency in cycles (1..15).
// Build option MEM_PORT_ARB_RR_EN: round-robin on contention (adds a
// last-grant pointer register); otherwise LSU has fixed priority.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus,
    output logic                  busy
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $fatal(1, "mem_port_arbiter: MEM_LAT=%0d outside 1..15", MEM_LAT);
    end

    localparam logic [ARB_CNT_W-1:0] CNT_LOAD = ARB_CNT_W'(MEM_LAT - 1);

    arb_state_t           state, state_nxt;
    logic [ARB_CNT_W-1:0] cnt;
    logic                 accept;
    logic                 pick_idx;
    logic                 any_valid;
    logic                 last_grant;
    logic                 win_idx;
    logic                 lat_we;
    logic [ADDR_W-1:0]    lat_addr;
    logic [DATA_W-1:0]    lat_wdata;
    logic [DATA_W-1:0]    rdata_q;

    arb_pick u_pick (
        .req_valid  (bus.req_valid),
        .last_grant (last_grant),
        .grant_idx  (pick_idx),
        .any_valid  (any_valid)
    );

`ifdef MEM_PORT_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= pick_idx;
        end
    end
`else
    assign last_grant = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            win_idx   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                win_idx   <= pick_idx;
                lat_we    <= bus.req_we[pick_idx];
                lat_addr  <= pick_idx ? bus.req_addr[2*ADDR_W-1:ADDR_W]
                                      : bus.req_addr[ADDR_W-1:0];
                lat_wdata <= pick_idx ? bus.req_wdata[2*DATA_W-1:DATA_W]
                                      : bus.req_wdata[DATA_W-1:0];
            end
            // Counter reaches zero in the cycle the memory data is valid.
            if (state == ISSUE) begin
                cnt <= CNT_LOAD;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // Writes leave the previous read data on rsp_rdata.
            if (state == WAIT && cnt == '0 && !lat_we) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.req_ready = accept ? grant_onehot(pick_idx) : 2'b00;
    assign bus.rsp_valid = (state == RESP) ? grant_onehot(win_idx) : 2'b00;
    assign bus.rsp_rdata = rdata_q;
    assign bus.mem_en    = (state == ISSUE);
    assign bus.mem_we    = (state == ISSUE) && lat_we;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Two arbiter instances (MEM_LAT=1 and MEM_LAT=4), each with a behavioural
// memory. A per-cycle reference model predicts grants, strobes, responses and
// read data from the access timeline. Define MEM_PORT_ARB_RR_EN for both the
// RTL and this bench to exercise the round-robin build.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int LAT0 = 1;
    localparam int LAT1 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0][1:0]      t_valid = '0;
    logic [1:0][1:0]      t_we    = '0;
    logic [1:0][2*AW-1:0] t_addr  = '0;
    logic [1:0][2*DW-1:0] t_wdata = '0;

    logic [1:0][1:0]    o_ready, o_rspv;
    logic [1:0][DW-1:0] o_rdata, o_mwdata;
    logic [1:0][AW-1:0] o_maddr;
    logic [1:0]         o_men, o_mwe, o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [DW-1:0] init_word(int a);
        if (a == 12'h010) return 32'h00A00093;
        return 32'(a + 1) * 32'h9E3779B9;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? LAT0 : LAT1;
        mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        logic [DW-1:0] mem  [1<<AW];
        logic [DW-1:0] pipe [16];

        assign bus.req_valid = t_valid[g];
        assign bus.req_we    = t_we[g];
        assign bus.req_addr  = t_addr[g];
        assign bus.req_wdata = t_wdata[g];
        assign bus.mem_rdata = pipe[LAT-1];
        assign o_ready[g]  = bus.req_ready;
        assign o_rspv[g]   = bus.rsp_valid;
        assign o_rdata[g]  = bus.rsp_rdata;
        assign o_men[g]    = bus.mem_en;
        assign o_mwe[g]    = bus.mem_we;
        assign o_maddr[g]  = bus.mem_addr;
        assign o_mwdata[g] = bus.mem_wdata;

        mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
            .clk  (clk),
            .rst  (rst),
            .bus  (bus),
            .busy (o_busy[g])
        );

        initial for (int a = 0; a < (1 << AW); a++) mem[a] = init_word(a);

        // Read data is valid exactly LAT cycles after mem_en; other cycles carry junk.
        always @(posedge clk) begin
            if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            pipe[0] <= bus.mem_en ? mem[bus.mem_addr] : DW'($urandom);
            for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
        end
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [2][1<<AW];
    int            m_acc [2] = '{-100, -100};
    int            m_w [2], m_ptr [2] = '{1, 1};
    logic          m_we [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wd [2], m_rdata [2] = '{0, 0};
    int            cyc = 0;

    // Observations used by the stimulus and directed checks.
    logic [1:0]    rdy_seen [2] = '{0, 0};
    logic [1:0]    rsp_seen [2];
    logic          men_we_seen [2];
    logic [AW-1:0] men_addr_seen [2];
    int acc_cnt [2] = '{0, 0}, rsp_cnt [2] = '{0, 0}, men_cnt [2] = '{0, 0}, busy_cnt [2] = '{0, 0};
    int acc_cyc [2], rsp_cyc [2], men_cyc [2], acc_busy [2];

    function automatic int lat_of(int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int pick(logic [1:0] v, int ptr);
        if (v == 2'b11) begin
`ifdef MEM_PORT_ARB_RR_EN
            return (ptr == 1) ? 0 : 1;
`else
            return 1;
`endif
        end
        return v[1] ? 1 : 0;
    endfunction

    task automatic model_step(int k);
        int d, w, lat;
        logic [1:0] exp_rdy, exp_rsp;
        lat = lat_of(k);
        rdy_seen[k] = o_ready[k];
        if (o_busy[k]) busy_cnt[k]++;
        if (o_men[k]) begin
            men_cnt[k]++; men_cyc[k] = cyc;
            men_we_seen[k] = o_mwe[k]; men_addr_seen[k] = o_maddr[k];
        end
        if (o_rspv[k] != 2'b00) begin rsp_cnt[k]++; rsp_cyc[k] = cyc; rsp_seen[k] = o_rspv[k]; end
        if (o_ready[k] != 2'b00) begin acc_cnt[k]++; acc_cyc[k] = cyc; acc_busy[k] = busy_cnt[k]; end
        if (rst) begin
            m_acc[k] = -100; m_ptr[k] = 1; m_rdata[k] = '0;
            check($sformatf("i%0d_rst_ready", k), o_ready[k], 0);
            check($sformatf("i%0d_rst_rspv", k), o_rspv[k], 0);
            check($sformatf("i%0d_rst_men", k), {o_men[k], o_mwe[k], o_busy[k]}, 0);
            check($sformatf("i%0d_rst_maddr", k), o_maddr[k], 0);
            check($sformatf("i%0d_rst_mwdata", k), o_mwdata[k], 0);
            check($sformatf("i%0d_rst_rdata", k), o_rdata[k], 0);
            return;
        end
        exp_rdy = 2'b00;
        if (cyc >= m_acc[k] + 3 + lat && t_valid[k] != 2'b00) begin
            w = pick(t_valid[k], m_ptr[k]);
            exp_rdy   = 2'(1 << w);
            m_acc[k]  = cyc; m_w[k] = w; m_ptr[k] = w;
            m_we[k]   = t_we[k][w];
            m_addr[k] = t_addr[k][w*AW +: AW];
            m_wd[k]   = t_wdata[k][w*DW +: DW];
        end
        d = cyc - m_acc[k];
        exp_rsp = 2'b00;
        if (d == 1 && m_we[k]) ref_mem[k][m_addr[k]] = m_wd[k];
        if (d == 2 + lat) begin
            exp_rsp = 2'(1 << m_w[k]);
            if (!m_we[k]) m_rdata[k] = ref_mem[k][m_addr[k]];
        end
        check($sformatf("i%0d_ready", k), o_ready[k], exp_rdy);
        check($sformatf("i%0d_men", k), o_men[k], d == 1);
        check($sformatf("i%0d_busy", k), o_busy[k], d >= 1 && d <= 2 + lat);
        check($sformatf("i%0d_rspv", k), o_rspv[k], exp_rsp);
        check($sformatf("i%0d_rdata", k), o_rdata[k], m_rdata[k]);
        if (d == 1) begin
            check($sformatf("i%0d_mwe", k), o_mwe[k], m_we[k]);
            check($sformatf("i%0d_maddr", k), o_maddr[k], m_addr[k]);
            check($sformatf("i%0d_mwdata", k), o_mwdata[k], m_wd[k]);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) model_step(k);
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(int k, int r, logic we, logic [AW-1:0] a, logic [DW-1:0] wd);
        t_we[k][r]             = we;
        t_addr[k][r*AW +: AW]  = a;
        t_wdata[k][r*DW +: DW] = wd;
        t_valid[k][r]          = 1'b1;
    endtask

    task automatic send(int k, int r, logic we, logic [AW-1:0] a, logic [DW-1:0] wd);
        set_req(k, r, we, a, wd);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (rdy_seen[k][r]) begin
                t_valid[k][r] = 1'b0;
                return;
            end
        end
        t_valid[k][r] = 1'b0;
        check($sformatf("i%0d_send_timeout", k), 1, 0);
    endtask

    task automatic wait_rsp(int k, int n0);
        for (int i = 0; i < 40; i++) begin
            if (rsp_cnt[k] != n0) return;
            @(posedge clk); #1;
        end
        check($sformatf("i%0d_rsp_timeout", k), 1, 0);
    endtask

    task automatic do_reset();
        t_valid = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return $urandom_range(0, 1) ? 12'hFFF : 12'h000;
        return AW'($urandom_range(0, 15));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, a0, c0, b0, ng;
        int grants [4];
        int exp_g [4];
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < (1 << AW); a++) ref_mem[k][a] = init_word(a);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle requesters: nothing accepted, no memory strobe.
        a0 = acc_cnt[0] + acc_cnt[1]; n0 = men_cnt[0] + men_cnt[1];
        repeat (8) @(posedge clk);
        #1;
        check("idle_no_accept", acc_cnt[0] + acc_cnt[1], a0);
        check("idle_no_men", men_cnt[0] + men_cnt[1], n0);

        // Fetch read of 0x010.
        n0 = rsp_cnt[0];
        send(0, 0, 1'b0, 12'h010, 32'h0);
        wait_rsp(0, n0);
        check("fetch_men_lat", men_cyc[0] - acc_cyc[0], 1);
        check("fetch_rsp_lat", rsp_cyc[0] - acc_cyc[0], 3);
        check("fetch_rsp_vec", rsp_seen[0], 2'b01);
        check("fetch_rdata", o_rdata[0], 32'h00A00093);

        // LSU write to the top word, then read it back.
        n0 = rsp_cnt[0];
        send(0, 1, 1'b1, 12'hFFF, 32'hDEADBEEF);
        wait_rsp(0, n0);
        check("lsu_wr_mwe", men_we_seen[0], 1);
        check("lsu_wr_maddr", men_addr_seen[0], 12'hFFF);
        check("lsu_wr_rsp_lat", rsp_cyc[0] - acc_cyc[0], 3);
        check("lsu_wr_rsp_vec", rsp_seen[0], 2'b10);
        check("lsu_wr_rdata_hold", o_rdata[0], 32'h00A00093);
        n0 = rsp_cnt[0];
        send(0, 1, 1'b0, 12'hFFF, 32'h0);
        wait_rsp(0, n0);
        check("lsu_readback", o_rdata[0], 32'hDEADBEEF);

        // Both requesters held valid for four accesses.
        do_reset();
`ifdef MEM_PORT_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{1, 1, 1, 1};
`endif
        set_req(0, 0, 1'b0, 12'h020, 32'h0);
        set_req(0, 1, 1'b0, 12'h030, 32'h0);
        ng = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            @(posedge clk); #1;
            if (rdy_seen[0] != 2'b00) begin
                grants[ng] = rdy_seen[0][1] ? 1 : 0;
                ng++;
            end
        end
        t_valid[0] = 2'b00;
        check("contend_grant_count", ng, 4);
        for (int i = 0; i < 4; i++) check($sformatf("contend_grant%0d", i), grants[i], exp_g[i]);

        // MEM_LAT=4 back-to-back fetches.
        do_reset();
        set_req(1, 0, 1'b0, 12'h005, 32'h0);
        ng = 0;
        for (int i = 0; i < 40 && ng < 2; i++) begin
            @(posedge clk); #1;
            if (rdy_seen[1][0]) begin
                if (ng == 0) begin c0 = acc_cyc[1]; b0 = acc_busy[1]; end
                ng++;
            end
        end
        t_valid[1] = 2'b00;
        check("lat4_accepts", ng, 2);
        check("lat4_accept_gap", acc_cyc[1] - c0, 7);
        check("lat4_busy_cycles", acc_busy[1] - b0, 6);

        // Reset while waiting on the memory: access dropped, no response.
        repeat (8) @(posedge clk);
        #1 n0 = rsp_cnt[1];
        send(1, 1, 1'b0, 12'h007, 32'h0);
        @(posedge clk);
        #1 do_reset();
        repeat (12) @(posedge clk);
        #1;
        check("rst_wait_no_rsp", rsp_cnt[1], n0);
        check("rst_wait_idle", o_busy[1], 0);

        // Randomized traffic on both instances.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 2; r++) begin
                    if (t_valid[k][r] && !rdy_seen[k][r]) continue;
                    if ($urandom_range(0, 99) < 55)
                        set_req(k, r, (r == 1) ? 1'($urandom_range(0, 1)) : 1'b0, rand_addr(), DW'($urandom));
                    else
                        t_valid[k][r] = 1'b0;
                end
            end
        end
        t_valid = '0;
        repeat (20) @(posedge clk);
        #1;
        check("drain_idle", o_busy, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
